// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer for a UART receiver.
//
// Stores each received byte with its parity/stop error tags in a
// first-word-fall-through circular buffer, and keeps a sticky overrun
// flag and three saturating event counters.
//
// Handshake: valid_in is a one-cycle strobe that qualifies data_in,
// parity_err_in and stop_err_in. The head entry is offered on rd_* while
// rd_valid is high. It is consumed on every rising edge where rd_valid and
// rd_ready are both high. rd_ready has no effect while rd_valid is low.
//
// Parameters
//   DEPTH    : number of entries (power of two, >= 2)
//   DROP_ERR : 1 = bytes carrying a parity or stop error are not stored
// Ports
//   clk, reset_n                         : clock, async active-low reset
//   data_in, valid_in                    : received byte and its strobe
//   parity_err_in, stop_err_in           : error tags for data_in
//   rd_ready                             : consumer takes the head entry
//   clr_status                           : clears overrun and the counters
//   rd_valid, rd_data                    : head entry present / head byte
//   rd_parity_err, rd_stop_err           : head entry error tags
//   count, full, empty                   : occupancy
//   overrun                              : sticky, a byte was dropped on full
//   parity_err_cnt, stop_err_cnt,
//   overrun_cnt                          : saturating event counters
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int DROP_ERR = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               data_in,
  input  logic                     valid_in,
  input  logic                     parity_err_in,
  input  logic                     stop_err_in,
  input  logic                     rd_ready,
  input  logic                     clr_status,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     rd_parity_err,
  output logic                     rd_stop_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overrun,
  output logic [7:0]               parity_err_cnt,
  output logic [7:0]               stop_err_cnt,
  output logic [7:0]               overrun_cnt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam bit          DROP     = (DROP_ERR != 0);

  // Entry layout: {stop_err, parity_err, data}
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    par_cnt_q, par_cnt_d;
  logic [7:0]    stp_cnt_q, stp_cnt_d;
  logic [7:0]    ovr_cnt_q, ovr_cnt_d;

  logic full_w, empty_w;
  logic accept, push, pop, drop_full;
  logic [9:0] head;

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);

  assign pop       = !empty_w && rd_ready;
  assign accept    = valid_in && !(DROP && (parity_err_in || stop_err_in));
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign push      = accept && (!full_w || pop);
  assign drop_full = accept && full_w && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps naturally.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    par_cnt_d = par_cnt_q;
    stp_cnt_d = stp_cnt_q;
    ovr_cnt_d = ovr_cnt_q;
    if (clr_status) begin
      // Clear wins over any increment arriving in the same cycle.
      overrun_d = 1'b0;
      par_cnt_d = '0;
      stp_cnt_d = '0;
      ovr_cnt_d = '0;
    end else begin
      if (drop_full) begin
        overrun_d = 1'b1;
        if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
      // Error counters see every strobe, stored or not.
      if (valid_in && parity_err_in && par_cnt_q != 8'hFF)
        par_cnt_d = par_cnt_q + 8'd1;
      if (valid_in && stop_err_in && stp_cnt_q != 8'hFF)
        stp_cnt_d = stp_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
      ovr_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      par_cnt_q <= par_cnt_d;
      stp_cnt_q <= stp_cnt_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  // Storage is not reset; the read port is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {stop_err_in, parity_err_in, data_in};
  end

  assign head = empty_w ? 10'd0 : mem_q[rd_ptr_q];

  assign rd_valid       = !empty_w;
  assign rd_data        = head[7:0];
  assign rd_parity_err  = head[8];
  assign rd_stop_err    = head[9];
  assign count          = count_q;
  assign full           = full_w;
  assign empty          = empty_w;
  assign overrun        = overrun_q;
  assign parity_err_cnt = par_cnt_q;
  assign stop_err_cnt   = stp_cnt_q;
  assign overrun_cnt    = ovr_cnt_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of receive entries; power of two, minimum 2.
REQ-002 SHALL have parameter DROP_ERR, default 0; when 1, bytes flagged with parity or stop error are not stored.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in  input  8  received byte from UART receiver.
REQ-006 SHALL have port valid_in  input  1  one-cycle strobe qualifying data_in and error inputs.
REQ-007 SHALL have port parity_err_in  input  1  parity error for the byte on data_in.
REQ-008 SHALL have port stop_err_in  input  1  stop-bit error for the byte on data_in.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port clr_status  input  1  one-cycle pulse clearing sticky flag and counters.
REQ-011 SHALL have port rd_valid  output  1  head entry present.
REQ-012 SHALL have port rd_data  output  8  head entry byte.
REQ-013 SHALL have port rd_parity_err  output  1  head entry parity-error tag.
REQ-014 SHALL have port rd_stop_err  output  1  head entry stop-error tag.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  entries held.
REQ-016 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.
REQ-017 SHALL have port overrun  output  1  sticky: a byte was dropped because FIFO was full.
REQ-018 SHALL have ports parity_err_cnt, stop_err_cnt, overrun_cnt  output  8 each  saturating event counters.

Function
REQ-019 SHALL store 10-bit entries {stop_err, parity_err, data} in a circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-020 SHALL be first-word-fall-through: rd_valid = !empty; rd_data/rd_*_err show head entry combinationally from storage, zero latency.
REQ-021 SHALL pop when rd_valid && rd_ready; rd_ready while empty has no effect.
REQ-022 SHALL define accept = valid_in && !(DROP_ERR && (parity_err_in || stop_err_in)).
REQ-023 SHALL push when accept && (!full || pop same cycle); written entry visible on rd_* the cycle after push if FIFO was empty (one-cycle latency input to output).
REQ-024 SHALL, on simultaneous push and pop, advance both pointers and leave count unchanged, including when full.
REQ-025 SHALL, when accept && full && !pop, discard the byte, set overrun, increment overrun_cnt.
REQ-026 SHALL increment parity_err_cnt on every valid_in with parity_err_in=1, and stop_err_cnt on every valid_in with stop_err_in=1, regardless of DROP_ERR or full.
REQ-027 SHALL saturate each counter at 255.
REQ-028 SHALL, on clr_status, zero overrun and all three counters next cycle; clr_status takes priority over a same-cycle increment or overrun set; FIFO contents unaffected.
REQ-029 SHALL keep count, full, empty registered-consistent with pointers every cycle; never count > DEPTH.

Reset
REQ-030 SHALL, while reset_n=0, asynchronously force pointers and count to 0, empty=1, full=0, rd_valid=0, overrun=0, all counters 0; rd_data/rd_*_err read 0 after reset (storage need not be cleared but outputs masked to 0 when empty).
REQ-031 SHALL discard in-flight push/pop on reset assertion mid-operation; first push after release lands at entry 0.

Verification
REQ-032 Reset, then valid_in with data_in=0x5A, errors 0, rd_ready=0 -> next cycle rd_valid=1, rd_data=0x5A, count=1, empty=0.
REQ-033 Push 16 bytes 0x00..0x0F with rd_ready=0, then push 0xFF -> full=1, count=16, overrun=1, overrun_cnt=1; draining yields 0x00..0x0F in order, 0xFF absent.
REQ-034 Full FIFO, valid_in (0xA5) and rd_ready same cycle -> count stays 16, overrun stays 0, 0xA5 read last.
REQ-035 DROP_ERR=1, valid_in 0x33 with parity_err_in=1 -> not stored, empty stays 1, parity_err_cnt=1; DROP_ERR=0 same stimulus -> stored with rd_parity_err=1.
REQ-036 300 stop-error strobes -> stop_err_cnt=255; clr_status coinciding with a further strobe -> stop_err_cnt=0.
REQ-037 Assert reset_n=0 with count=5 -> immediately empty=1, count=0, rd_valid=0; after release, push 0x11 reads back as 0x11.
